// File: rtl/card_shoe.sv
// card_shoe: card source for the blackjack controller.
//   Random modes (mode 0, 5..7) deal from a finite NUM_DECKS shoe: a 16-bit
//   Galois LFSR picks a starting rank and empty ranks are skipped by probing.
//   Scripted modes (1..4) replay fixed 8-card sequences for repeatable hands.
// Ports:
//   clk, reset      - rising-edge clock, synchronous active-low reset
//   mode[2:0]       - source select, latched at reset release / reshuffle
//   draw_req        - request one card (sampled in IDLE only)
//   reshuffle       - refill shoe, rewind script (IDLE only)
//   card[5:0]       - card value 2..11, held until next delivery
//   card_valid      - one-cycle pulse with each delivered card
//   busy            - high while a draw is in flight
//   cards_left[7:0] - cards remaining in the shoe
//   reshuffle_due   - shoe below penetration (random modes only)
//   draw_err        - one-cycle pulse on a draw from an empty shoe
module card_shoe #(
  parameter int          NUM_DECKS   = 1,
  parameter int          PENETRATION = 15,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] mode,
  input  logic       draw_req,
  input  logic       reshuffle,
  output logic [5:0] card,
  output logic       card_valid,
  output logic       busy,
  output logic [7:0] cards_left,
  output logic       reshuffle_due,
  output logic       draw_err
);

  // An all-zero Galois LFSR would lock up, so a zero seed is remapped.
  localparam logic [15:0] SEED      = (LFSR_SEED == 16'h0) ? 16'h0001 : LFSR_SEED;
  localparam logic [4:0]  RANK_FULL = 5'(4 * NUM_DECKS);
  localparam logic [7:0]  SHOE_FULL = 8'(52 * NUM_DECKS);

  // Script rows, element 0 in the low nibble (dealer cards first).
  localparam logic [31:0] SCR1 = {4'd5, 4'd3, 4'd2, 4'd4, 4'd8, 4'd10, 4'd7, 4'd9};
  localparam logic [31:0] SCR2 = {4'd6, 4'd5, 4'd3, 4'd2, 4'd8, 4'd10, 4'd7, 4'd9};
  localparam logic [31:0] SCR3 = {4'd6, 4'd5, 4'd3, 4'd2, 4'd11, 4'd10, 4'd7, 4'd9};
  localparam logic [31:0] SCR4 = {4'd2, 4'd8, 4'd4, 4'd8, 4'd10, 4'd10, 4'd7, 4'd9};

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_e;

  state_e          state_q, state_d;
  logic [12:0][4:0] cnt_q, cnt_d;
  logic [7:0]      left_q, left_d;
  logic [3:0]      idx_q, idx_d;
  logic [2:0]      sidx_q, sidx_d;
  logic [2:0]      mode_q, mode_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [5:0]      card_q, card_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            due_q, due_d;
  logic            err_q, err_d;

  function automatic logic is_rand(input logic [2:0] m);
    return (m == 3'd0) || (m >= 3'd5);
  endfunction

  // Rank order 2..10, J, Q, K, A.
  function automatic logic [5:0] rank_val(input logic [3:0] r);
    if (r <= 4'd8)       return {2'b00, r} + 6'd2;
    else if (r <= 4'd11) return 6'd10;
    else                 return 6'd11;
  endfunction

  function automatic logic [5:0] script_val(input logic [2:0] m, input logic [2:0] i);
    logic [31:0] row;
    case (m)
      3'd1:    row = SCR1;
      3'd2:    row = SCR2;
      3'd3:    row = SCR3;
      default: row = SCR4;
    endcase
    return {2'b00, row[{i, 2'b00} +: 4]};
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    idx_d   = idx_q;
    sidx_d  = sidx_q;
    mode_d  = mode_q;
    card_d  = card_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    // Free-running so the rank pick depends on request timing.
    lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    case (state_q)
      IDLE: begin
        if (reshuffle) begin
          // A same-cycle draw_req is intentionally dropped.
          for (int r = 0; r < 13; r++) cnt_d[r] = RANK_FULL;
          left_d = SHOE_FULL;
          sidx_d = 3'd0;
          mode_d = mode;
        end else if (draw_req) begin
          if (!is_rand(mode_q)) begin
            state_d = SEARCH;
          end else if (left_q == 8'd0) begin
            err_d = 1'b1;
          end else begin
            // Fold 13..15 back onto 0..2; the resulting bias is accepted.
            idx_d   = (lfsr_q[3:0] >= 4'd13) ? lfsr_q[3:0] - 4'd13 : lfsr_q[3:0];
            state_d = SEARCH;
          end
        end
      end
      SEARCH: begin
        if (!is_rand(mode_q)) begin
          card_d  = script_val(mode_q, sidx_q);
          sidx_d  = sidx_q + 3'd1;
          valid_d = 1'b1;
          state_d = DONE;
        end else if (cnt_q[idx_q] != 5'd0) begin
          cnt_d[idx_q] = cnt_q[idx_q] - 5'd1;
          left_d       = left_q - 8'd1;
          card_d       = rank_val(idx_q);
          valid_d      = 1'b1;
          state_d      = DONE;
        end else begin
          // Shoe is non-empty, so probing terminates within 12 steps.
          idx_d = (idx_q == 4'd12) ? 4'd0 : idx_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    due_d  = is_rand(mode_d) && (int'(left_d) < PENETRATION);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= {13{RANK_FULL}};
      left_q  <= SHOE_FULL;
      idx_q   <= 4'd0;
      sidx_q  <= 3'd0;
      mode_q  <= mode;  // last value seen while in reset is the one kept
      lfsr_q  <= SEED;
      card_q  <= 6'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      due_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      idx_q   <= idx_d;
      sidx_q  <= sidx_d;
      mode_q  <= mode_d;
      lfsr_q  <= lfsr_d;
      card_q  <= card_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      due_q   <= due_d;
      err_q   <= err_d;
    end
  end

  assign card          = card_q;
  assign card_valid    = valid_q;
  assign busy          = busy_q;
  assign cards_left    = left_q;
  assign reshuffle_due = due_q;
  assign draw_err      = err_q;

endmodule
